// File: rtl/sys_array_result_streamer.sv
// sys_array_result_streamer
// Drain side of the systolic array fetcher. A rising edge on comp_ready snapshots
// the ARRAY_A_W x ARRAY_W_L result matrix into an internal buffer. The buffer is
// then streamed out row-major, one signed element per valid/ready handshake.
// in_data layout: element [r][c] occupies bits [(r*ARRAY_W_L+c)*EW +: EW].
module sys_array_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 4,
    parameter int ARRAY_W_L  = 4,
    localparam int EW = 2 * DATA_WIDTH,
    localparam int RW = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1,
    localparam int CW = (ARRAY_W_L > 1) ? $clog2(ARRAY_W_L) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 comp_ready,
    input  logic [ARRAY_A_W*ARRAY_W_L*EW-1:0]    in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [EW-1:0]                 out_data,
    output logic [RW-1:0]                        out_row,
    output logic [CW-1:0]                        out_col,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [RW-1:0]      row_reg;
    logic [RW-1:0]      row_next;
    logic [CW-1:0]      col_reg;
    logic [CW-1:0]      col_next;
    logic               comp_ready_q_reg;
    logic               overrun_reg;
    logic               overrun_set;
    logic               load;
    logic               new_res;
    logic               is_last;
    logic signed [EW-1:0] buf_reg [ARRAY_A_W][ARRAY_W_L];

    // A result is new only on the 0->1 transition of the fetcher's ready level.
    assign new_res = comp_ready & ~comp_ready_q_reg;
    assign is_last = (row_reg == RW'(ARRAY_A_W - 1)) && (col_reg == CW'(ARRAY_W_L - 1));

    // Edge-detect history; resets high so a level already up at release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            comp_ready_q_reg <= 1'b1;
        end else begin
            comp_ready_q_reg <= comp_ready;
        end
    end

    // State, indices and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            col_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Snapshot of the whole result matrix; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < ARRAY_A_W; r++) begin
                for (int c = 0; c < ARRAY_W_L; c++) begin
                    buf_reg[r][c] <= in_data[(r*ARRAY_W_L + c)*EW +: EW];
                end
            end
        end
    end

    // Next-state logic: capture on new result, walk row-major on handshakes.
    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        load        = 1'b0;
        overrun_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (new_res) begin
                    load       = 1'b1;
                    row_next   = '0;
                    col_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // A result arriving mid-stream is dropped; the buffer stays intact.
                if (new_res) begin
                    overrun_set = 1'b1;
                end
                if (out_ready) begin
                    if (is_last) begin
                        row_next   = '0;
                        col_next   = '0;
                        state_next = DONE;
                    end else if (col_reg == CW'(ARRAY_W_L - 1)) begin
                        col_next = '0;
                        row_next = row_reg + RW'(1);
                    end else begin
                        col_next = col_reg + CW'(1);
                    end
                end
            end
            DONE: begin
                // A result landing in the DONE cycle starts the next stream directly.
                if (new_res) begin
                    load       = 1'b1;
                    row_next   = '0;
                    col_next   = '0;
                    state_next = STREAM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are pure functions of registered state, so they hold while stalled.
    always_comb begin
        out_valid = (state_reg == STREAM);
        busy      = (state_reg == STREAM);
        done      = (state_reg == DONE);
        out_last  = (state_reg == STREAM) && is_last;
        out_row   = row_reg;
        out_col   = col_reg;
        overrun   = overrun_reg;
        out_data  = (state_reg == STREAM) ? buf_reg[row_reg][col_reg] : '0;
    end

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Directed bench for sys_array_result_streamer (default 4x4, 16-bit elements).
`timescale 1ns/1ps
module tb_sys_array_result_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         comp_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] mats [2][16];

    sys_array_result_streamer #(
        .DATA_WIDTH(8),
        .ARRAY_A_W (4),
        .ARRAY_W_L (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .comp_ready(comp_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pack(input int sel);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) p[k*16 +: 16] = mats[sel][k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element 0 of matrix sel is on the outputs; drain with out_ready=1 and land in DONE.
    task automatic drain_matrix(input int sel, input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== mats[sel][k] ||
                out_row !== 2'(k / 4) || out_col !== 2'(k % 4) ||
                out_last !== (k == 15) || done !== 1'b0) begin
                errors++;
                $display("FAIL %s elem %0d: got v=%b d=%h r=%0d c=%0d l=%b dn=%b, want v=1 d=%h r=%0d c=%0d l=%b dn=0",
                         tag, k, out_valid, out_data, out_row, out_col, out_last, done,
                         mats[sel][k], k / 4, k % 4, (k == 15));
            end
            $display("%s: elem %0d row=%0d col=%0d data=%h last=%b", tag, k, out_row, out_col, out_data, out_last);
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: got done=%b valid=%b busy=%b, want 1 0 0", tag, done, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        comp_ready = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            overrun !== 1'b0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b o=%b r=%0d c=%0d, want all 0",
                     out_valid, out_last, busy, done, overrun, out_row, out_col);
        end
        $display("reset: outputs idle");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream_full();
        comp_ready = 1'b1;
        in_data = pack(0);
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency: got out_valid=%b before edge, want 0", out_valid);
        end
        tick();
        drain_matrix(0, "stream_full");
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: got done=%b valid=%b, want 0 0", done, out_valid);
        end
        comp_ready = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int idx = 0;
        int cyc = 0;
        comp_ready = 1'b1;
        in_data = pack(1);
        tick();
        while (idx < 16 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== mats[1][idx] || out_row !== 2'(idx / 4) ||
                out_col !== 2'(idx % 4) || out_last !== (idx == 15)) begin
                errors++;
                $display("FAIL stall elem %0d cyc %0d: got v=%b d=%h r=%0d c=%0d l=%b, want v=1 d=%h r=%0d c=%0d",
                         idx, cyc, out_valid, out_data, out_row, out_col, out_last,
                         mats[1][idx], idx / 4, idx % 4);
            end
            $display("stall: cyc %0d elem %0d ready=%b data=%h", cyc, idx, out_ready, out_data);
            if (out_valid && out_ready) idx++;
            tick();
            cyc++;
        end
        checks++;
        if (idx !== 16 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_count: got handshakes=%0d done=%b, want 16 1", idx, done);
        end
        out_ready = 1'b1;
        comp_ready = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        comp_ready = 1'b1;
        in_data = pack(0);
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 2) comp_ready = 1'b0;
            if (k == 5) begin
                comp_ready = 1'b1;
                in_data = pack(1);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== mats[0][k] || overrun !== (k > 5)) begin
                errors++;
                $display("FAIL overrun elem %0d: got v=%b d=%h ovr=%b, want v=1 d=%h ovr=%b",
                         k, out_valid, out_data, overrun, mats[0][k], (k > 5));
            end
            $display("overrun: elem %0d data=%h overrun=%b", k, out_data, overrun);
            tick();
        end
        checks++;
        if (done !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got done=%b ovr=%b, want 1 1", done, overrun);
        end
        tick();
        comp_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_idle: got valid=%b ovr=%b, want 0 1", out_valid, overrun);
        end
    endtask

    task automatic test_ready_at_reset();
        comp_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL level_at_reset cyc %0d: got v=%b b=%b ovr=%b, want 0 0 0",
                         i, out_valid, busy, overrun);
            end
            $display("level_at_reset: cyc %0d valid=%b", i, out_valid);
        end
        comp_ready = 1'b0;
        tick();
        comp_ready = 1'b1;
        in_data = pack(0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reraise_latency: got out_valid=%b before edge, want 0", out_valid);
        end
        tick();
        drain_matrix(0, "reraise");
        comp_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        comp_ready = 1'b1;
        in_data = pack(1);
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            if (k == 2) comp_ready = 1'b0;
            if (k == 4) comp_ready = 1'b1;
            tick();
        end
        checks++;
        if (out_data !== mats[1][7] || overrun !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset elem 7: got d=%h ovr=%b, want d=%h ovr=1", out_data, overrun, mats[1][7]);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            out_row !== 2'd0 || out_col !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b b=%b ovr=%b r=%0d c=%0d, want all 0",
                     out_valid, busy, overrun, out_row, out_col);
        end
        $display("reset_mid: stream aborted at elem 7");
        reset = 1'b0;
        comp_ready = 1'b0;
        tick();
        comp_ready = 1'b1;
        in_data = pack(0);
        tick();
        drain_matrix(0, "restart");
        comp_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        comp_ready = 1'b1;
        in_data = pack(0);
        out_ready = 1'b1;
        tick();
        comp_ready = 1'b0;
        drain_matrix(0, "b2b_first");
        comp_ready = 1'b1;
        in_data = pack(1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== mats[1][0] || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got v=%b d=%h ovr=%b, want v=1 d=%h ovr=0",
                     out_valid, out_data, overrun, mats[1][0]);
        end
        drain_matrix(1, "b2b_second");
        comp_ready = 1'b0;
        tick();
    endtask

    initial begin
        mats[0] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0123, 16'hFEDC, 16'h00FF, 16'hFF00,
                    16'h1234, 16'hEDCB, 16'h0010, 16'hFFF0, 16'h4000, 16'hC000, 16'h0A0A, 16'hF5F5};
        mats[1] = '{16'h1000, 16'h2101, 16'h3202, 16'hC303, 16'h0404, 16'hF505, 16'h0606, 16'h8707,
                    16'h0808, 16'hE909, 16'h0A0A, 16'h5B0B, 16'hFC0C, 16'h0D0D, 16'h6E0E, 16'h0F0F};
        test_reset();
        test_stream_full();
        test_stall();
        test_overrun();
        test_ready_at_reset();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
